// File: rtl/pong_pkg.sv
// Shared types and widths for the pong match sequencer and its helpers.
package pong_pkg;

  localparam int SCORE_W = 3;
  localparam int LEVEL_W = 3;

  // Encoding doubles as the status-display code on state_o.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SERVE_WAIT  = 3'd1,
    ST_RALLY       = 3'd2,
    ST_POINT_PAUSE = 3'd3,
    ST_PAUSED      = 3'd4,
    ST_WIN_HOLD    = 3'd5,
    ST_GAME_OVER   = 3'd6
  } match_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

  // Down-counter width able to hold the larger of the two reload values.
  function automatic int timerWidth(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pong_tick_timer.sv
// Loadable down-counter shared by the serve and win-hold delays; done while at zero.
module pong_tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_value_i,
  input  logic         enable_i,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;

  // A load always wins; otherwise count down and rest at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (enable_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/pong_match_sequencer.sv
// Match-level FSM: serve/rally/pause sequencing, scores, level progression and winner.
module pong_match_sequencer
  import pong_pkg::*;
#(
  parameter int WIN_SCORE      = 7,
  parameter int MAX_LEVEL      = 7,
  parameter int SERVE_TICKS    = 25000000,
  parameter int WIN_HOLD_TICKS = 100000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               p1_point,
  input  logic               p2_point,
  output logic               game_on,
  output logic               ball_reset,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [LEVEL_W-1:0] level,
  output logic               lvl_up,
  output logic [1:0]         winner,
  output logic [2:0]         state_o
);

  localparam int TIMER_W = timerWidth(SERVE_TICKS, WIN_HOLD_TICKS);
  localparam logic [TIMER_W-1:0] SERVE_LOAD = TIMER_W'(SERVE_TICKS - 1);
  localparam logic [TIMER_W-1:0] HOLD_LOAD  = TIMER_W'(WIN_HOLD_TICKS - 1);
  localparam logic [SCORE_W-1:0] WIN_PTS    = SCORE_W'(WIN_SCORE);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(MAX_LEVEL);

  match_state_t       state_q, state_d, saved_q, saved_d;
  winner_t            winner_q, winner_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d, p1_inc, p2_inc;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               lvl_up_q, lvl_up_d, game_on_q, ball_reset_q;
  logic               timer_load, timer_done;
  logic [TIMER_W-1:0] timer_value;

  assign p1_inc = (p1_q == WIN_PTS) ? p1_q : p1_q + SCORE_W'(1);
  assign p2_inc = (p2_q == WIN_PTS) ? p2_q : p2_q + SCORE_W'(1);

  pong_tick_timer #(.W(TIMER_W)) u_timer (
    .clk          (clk),
    .reset        (reset),
    .load_i       (timer_load),
    .load_value_i (timer_value),
    .enable_i     (state_q != ST_PAUSED),
    .done_o       (timer_done)
  );

  // Next-state logic; a point in RALLY takes precedence over a same-cycle pause.
  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    winner_d    = winner_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    level_d     = level_q;
    lvl_up_d    = 1'b0;
    timer_load  = 1'b0;
    timer_value = SERVE_LOAD;
    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_btn) begin
          state_d    = ST_SERVE_WAIT;
          p1_d       = '0;
          p2_d       = '0;
          level_d    = LEVEL_W'(1);
          winner_d   = WIN_NONE;
          timer_load = 1'b1;
        end
      end
      ST_SERVE_WAIT, ST_POINT_PAUSE: begin
        if (pause_btn) begin
          saved_d = state_q;
          state_d = ST_PAUSED;
        end else if (timer_done) begin
          state_d = ST_RALLY;
        end
      end
      ST_RALLY: begin
        if (p1_point && p2_point) begin
          state_d    = ST_POINT_PAUSE;
          timer_load = 1'b1;
        end else if (p1_point || p2_point) begin
          p1_d       = p1_point ? p1_inc : p1_q;
          p2_d       = p2_point ? p2_inc : p2_q;
          timer_load = 1'b1;
          if ((p1_point ? p1_inc : p2_inc) == WIN_PTS) begin
            state_d     = ST_WIN_HOLD;
            winner_d    = p1_point ? WIN_P1 : WIN_P2;
            timer_value = HOLD_LOAD;
          end else begin
            state_d = ST_POINT_PAUSE;
          end
        end else if (pause_btn) begin
          saved_d = ST_RALLY;
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (pause_btn) begin
          state_d = saved_q;
        end
      end
      ST_WIN_HOLD: begin
        if (timer_done) begin
          if (level_q < LAST_LEVEL) begin
            state_d    = ST_SERVE_WAIT;
            lvl_up_d   = 1'b1;
            level_d    = level_q + LEVEL_W'(1);
            p1_d       = '0;
            p2_d       = '0;
            winner_d   = WIN_NONE;
            timer_load = 1'b1;
          end else begin
            state_d = ST_GAME_OVER;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Motion-control outputs are registered from the next state so they track state_o.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      saved_q      <= ST_SERVE_WAIT;
      winner_q     <= WIN_NONE;
      p1_q         <= '0;
      p2_q         <= '0;
      level_q      <= LEVEL_W'(1);
      lvl_up_q     <= 1'b0;
      game_on_q    <= 1'b0;
      ball_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      saved_q      <= saved_d;
      winner_q     <= winner_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      level_q      <= level_d;
      lvl_up_q     <= lvl_up_d;
      game_on_q    <= (state_d == ST_RALLY);
      ball_reset_q <= !((state_d == ST_RALLY) || (state_d == ST_PAUSED));
    end
  end

  assign game_on    = game_on_q;
  assign ball_reset = ball_reset_q;
  assign p1_score   = p1_q;
  assign p2_score   = p2_q;
  assign level      = level_q;
  assign lvl_up     = lvl_up_q;
  assign winner     = winner_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Scoreboard bench for pong_match_sequencer: stimulus queues cycle-stamped expectations, a monitor checks them.
module tb_pong_match_sequencer;

  localparam int S_IDLE = 0, S_SW = 1, S_RALLY = 2, S_PP = 3, S_PAUSED = 4, S_WH = 5, S_GO = 6;

  logic clk = 1'b0;
  logic reset, start_btn, pause_btn, p1_point, p2_point;
  logic game_on, ball_reset, lvl_up;
  logic [2:0] p1_score, p2_score, level, state_o;
  logic [1:0] winner;
  logic [16:0] snap;

  typedef struct {
    int          cyc;
    string       name;
    logic [16:0] val;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  pong_match_sequencer #(
    .WIN_SCORE(3), .MAX_LEVEL(2), .SERVE_TICKS(4), .WIN_HOLD_TICKS(6)
  ) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn),
    .p1_point(p1_point), .p2_point(p2_point), .game_on(game_on), .ball_reset(ball_reset),
    .p1_score(p1_score), .p2_score(p2_score), .level(level), .lvl_up(lvl_up),
    .winner(winner), .state_o(state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign snap = {state_o, game_on, ball_reset, p1_score, p2_score, level, lvl_up, winner};

  function automatic logic [16:0] mk(input int st, input int gon, input int br, input int s1,
                                     input int s2, input int lv, input int lu, input int w);
    return {3'(st), 1'(gon), 1'(br), 3'(s1), 3'(s2), 3'(lv), 1'(lu), 2'(w)};
  endfunction

  task automatic checkOutput(input string name, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d got st=%0d on=%b br=%b p1=%0d p2=%0d lvl=%0d up=%b win=%b, expected st=%0d on=%b br=%b p1=%0d p2=%0d lvl=%0d up=%b win=%b",
               name, cyc, got[16:14], got[13], got[12], got[11:9], got[8:6], got[5:3], got[2], got[1:0],
               exp[16:14], exp[13], exp[12], exp[11:9], exp[8:6], exp[5:3], exp[2], exp[1:0]);
    end
  endtask

  task automatic expectRange(input int from, input int to, input string name, input logic [16:0] v);
    exp_t e;
    for (int i = from; i <= to; i++) begin
      e.cyc  = cyc + i;
      e.name = name;
      e.val  = v;
      expQ.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic pa, input logic a, input logic b);
    start_btn = s;
    pause_btn = pa;
    p1_point  = a;
    p2_point  = b;
    @(negedge clk);
    start_btn = 1'b0;
    pause_btn = 1'b0;
    p1_point  = 1'b0;
    p2_point  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare every queued expectation on the cycle it is stamped for.
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
      cur = expQ.pop_front();
      if (cur.cyc < cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s missed at cyc=%0d (now %0d)", cur.name, cur.cyc, cyc);
      end else begin
        checkOutput(cur.name, snap, cur.val);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [16:0] rstv;
    rstv = mk(S_IDLE, 0, 1, 0, 0, 1, 0, 0);
    reset = 1'b0; start_btn = 1'b0; pause_btn = 1'b0; p1_point = 1'b0; p2_point = 1'b0;
    idle(2);
    expectRange(1, 1, "reset_vals", rstv);
    idle(1);
    reset = 1'b1;
    idle(1);

    expectRange(1, 4, "serve_wait", mk(S_SW, 0, 1, 0, 0, 1, 0, 0));
    expectRange(5, 5, "rally_on", mk(S_RALLY, 1, 0, 0, 0, 1, 0, 0));
    applyStimulus(1, 0, 0, 0); idle(4);

    expectRange(1, 4, "p1_point_pause", mk(S_PP, 0, 1, 1, 0, 1, 0, 0));
    expectRange(5, 5, "p1_rally", mk(S_RALLY, 1, 0, 1, 0, 1, 0, 0));
    applyStimulus(0, 0, 1, 0); idle(4);

    expectRange(1, 4, "both_replay", mk(S_PP, 0, 1, 1, 0, 1, 0, 0));
    expectRange(5, 5, "both_rally", mk(S_RALLY, 1, 0, 1, 0, 1, 0, 0));
    applyStimulus(0, 0, 1, 1); idle(4);

    expectRange(1, 4, "point_beats_pause", mk(S_PP, 0, 1, 1, 1, 1, 0, 0));
    expectRange(5, 5, "p2a_rally", mk(S_RALLY, 1, 0, 1, 1, 1, 0, 0));
    applyStimulus(0, 1, 0, 1); idle(4);

    expectRange(1, 4, "p2b_pause", mk(S_PP, 0, 1, 1, 2, 1, 0, 0));
    expectRange(5, 5, "p2b_rally", mk(S_RALLY, 1, 0, 1, 2, 1, 0, 0));
    applyStimulus(0, 0, 0, 1); idle(4);

    expectRange(1, 6, "win_hold_l1", mk(S_WH, 0, 1, 1, 3, 1, 0, 2));
    expectRange(7, 7, "lvl_up_pulse", mk(S_SW, 0, 1, 0, 0, 2, 1, 0));
    expectRange(8, 10, "serve_l2", mk(S_SW, 0, 1, 0, 0, 2, 0, 0));
    expectRange(11, 11, "rally_l2", mk(S_RALLY, 1, 0, 0, 0, 2, 0, 0));
    applyStimulus(0, 0, 0, 1); idle(10);

    expectRange(1, 4, "l2_p1a_pause", mk(S_PP, 0, 1, 1, 0, 2, 0, 0));
    expectRange(5, 5, "l2_p1a_rally", mk(S_RALLY, 1, 0, 1, 0, 2, 0, 0));
    applyStimulus(0, 0, 1, 0); idle(4);
    expectRange(1, 4, "l2_p1b_pause", mk(S_PP, 0, 1, 2, 0, 2, 0, 0));
    expectRange(5, 5, "l2_p1b_rally", mk(S_RALLY, 1, 0, 2, 0, 2, 0, 0));
    applyStimulus(0, 0, 1, 0); idle(4);
    expectRange(1, 6, "win_hold_l2", mk(S_WH, 0, 1, 3, 0, 2, 0, 1));
    expectRange(7, 9, "game_over", mk(S_GO, 0, 1, 3, 0, 2, 0, 1));
    applyStimulus(0, 0, 1, 0); idle(8);
    expectRange(1, 1, "go_pause_ignored", mk(S_GO, 0, 1, 3, 0, 2, 0, 1));
    applyStimulus(0, 1, 0, 0);

    expectRange(1, 4, "restart_serve", mk(S_SW, 0, 1, 0, 0, 1, 0, 0));
    expectRange(5, 5, "restart_rally", mk(S_RALLY, 1, 0, 0, 0, 1, 0, 0));
    applyStimulus(1, 0, 0, 0); idle(4);
    expectRange(1, 1, "start_ignored", mk(S_RALLY, 1, 0, 0, 0, 1, 0, 0));
    applyStimulus(1, 0, 0, 0);

    idle(1);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    idle(1);
    expectRange(1, 2, "pre_pause_serve", mk(S_SW, 0, 1, 0, 0, 1, 0, 0));
    expectRange(3, 5, "paused", mk(S_PAUSED, 0, 0, 0, 0, 1, 0, 0));
    expectRange(6, 7, "resumed_serve", mk(S_SW, 0, 1, 0, 0, 1, 0, 0));
    expectRange(8, 8, "resumed_rally", mk(S_RALLY, 1, 0, 0, 0, 1, 0, 0));
    applyStimulus(1, 0, 0, 0); idle(1);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0); idle(1);
    applyStimulus(0, 1, 0, 0); idle(2);

    expectRange(1, 4, "r_p1a_pause", mk(S_PP, 0, 1, 1, 0, 1, 0, 0));
    expectRange(5, 5, "r_p1a_rally", mk(S_RALLY, 1, 0, 1, 0, 1, 0, 0));
    applyStimulus(0, 0, 1, 0); idle(4);
    expectRange(1, 4, "r_p1b_pause", mk(S_PP, 0, 1, 2, 0, 1, 0, 0));
    expectRange(5, 5, "r_p1b_rally", mk(S_RALLY, 1, 0, 2, 0, 1, 0, 0));
    applyStimulus(0, 0, 1, 0); idle(4);
    expectRange(1, 2, "wh_before_reset", mk(S_WH, 0, 1, 3, 0, 1, 0, 1));
    applyStimulus(0, 0, 1, 0); idle(1);

    expectRange(1, 10, "reset_from_wh", rstv);
    #1 reset = 1'b0;
    #3 checkOutput("async_reset_immediate", snap, rstv);
    idle(2);
    reset = 1'b1;
    idle(10);

    if (expQ.size() != 0) begin
      $display("[TB] FAIL leftover_expectations count=%0d required=0", expQ.size());
      checks += expQ.size();
      failures += expQ.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_match_sequencer.md
Name: pong_match_sequencer

Overview:
- Match-level FSM sitting directly upstream of the top-level game controller.
- Consumes point pulses from the ball engine and button pulses from the input conditioners.
- Produces game_on/serve control, running scores, current level, a one-cycle level-up pulse for audio, and the winner indication.
- Replaces ad-hoc score/level handling at the top level with one owned, timed state machine.

Parameters:
- WIN_SCORE, 7, points needed to win a level; width 3 bits; legal range 1..7.
- MAX_LEVEL, 7, highest level; a win at this level ends the match.
- SERVE_TICKS, 25000000, clk cycles spent in SERVE_WAIT before play resumes (0.5 s at 50 MHz); minimum 1.
- WIN_HOLD_TICKS, 100000000, clk cycles the winner is displayed before level advance; minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- start_btn  in  1  single-cycle pulse; starts a match from IDLE or GAME_OVER.
- pause_btn  in  1  single-cycle pulse; toggles pause.
- p1_point  in  1  single-cycle pulse; player 1 scored.
- p2_point  in  1  single-cycle pulse; player 2 scored.
- game_on  out  1  high only in RALLY; enables paddles and ball motion.
- ball_reset  out  1  high in every state except RALLY and PAUSED; holds the ball at centre.
- p1_score  out  3  player 1 points in the current level.
- p2_score  out  3  player 2 points in the current level.
- level  out  3  current level, 1..MAX_LEVEL.
- lvl_up  out  1  one-cycle pulse on level advance.
- winner  out  2  00 none, 01 P1, 10 P2; valid in WIN_HOLD and GAME_OVER.
- state_o  out  3  encoded FSM state, for the status display.

Behaviour:
- Reset (async assert, sync release) values:
  - state=IDLE; scores=0; level=1; winner=00; lvl_up=0; timer=0; saved_state=SERVE_WAIT.
  - game_on=0; ball_reset=1.
- All outputs are registered; one cycle latency from input pulse to output change.
- States: IDLE, SERVE_WAIT, RALLY, POINT_PAUSE, PAUSED, WIN_HOLD, GAME_OVER.
- IDLE:
  - start_btn -> SERVE_WAIT; clears scores; level=1; loads timer.
- SERVE_WAIT:
  - Timer counts down from SERVE_TICKS-1; on reaching 0 -> RALLY.
- RALLY:
  - Exactly one of p1_point/p2_point: increment that score.
  - If the new score == WIN_SCORE -> WIN_HOLD; set winner; load timer with WIN_HOLD_TICKS-1.
  - Otherwise -> POINT_PAUSE; load timer with SERVE_TICKS-1.
  - Both point pulses in the same cycle: no score change -> POINT_PAUSE (replay).
- POINT_PAUSE:
  - Identical timing to SERVE_WAIT; exit -> RALLY.
  - Kept as a distinct state so the display can distinguish it.
- PAUSED:
  - Entered from SERVE_WAIT, RALLY or POINT_PAUSE on pause_btn; the originating state goes to saved_state.
  - Timer is frozen and point pulses are ignored.
  - pause_btn -> return to saved_state with the timer value unchanged.
- Point vs pause priority: in RALLY, a point pulse wins over pause_btn in the same cycle; pause_btn is then dropped.
- pause_btn is ignored in IDLE, WIN_HOLD and GAME_OVER.
- WIN_HOLD:
  - Timer expiry with level < MAX_LEVEL:
    - lvl_up=1 for exactly one cycle; level+1; scores cleared; winner=00.
    - -> SERVE_WAIT with timer reloaded.
  - Timer expiry with level == MAX_LEVEL -> GAME_OVER; level stays at MAX_LEVEL (saturate, never wraps); no lvl_up pulse.
- GAME_OVER:
  - Scores and winner are held.
  - start_btn -> behaves as start from IDLE (clears everything, level=1, -> SERVE_WAIT).
- start_btn is ignored in every state except IDLE and GAME_OVER.
- Scores never exceed WIN_SCORE; 3-bit arithmetic with no wrap.
- Timer width is $clog2 of the larger of SERVE_TICKS and WIN_HOLD_TICKS; it is a down-counter.
- Asserting reset in any state returns to IDLE immediately; any pending lvl_up is cancelled.

Decomposition:
- Shared package pong_pkg:
  - match_state_t enum, 3-bit encoding IDLE=0 through GAME_OVER=6; this encoding also drives state_o.
  - winner_t encoding.
  - SCORE_W=3 and LEVEL_W=3 constants.
- One sub-module, pong_tick_timer:
  - Loadable down-counter with load, load_value, enable (frozen while PAUSED) and a done flag.
  - Used for both the serve and win-hold delays.

Test Plan (bench parameters SERVE_TICKS=4, WIN_HOLD_TICKS=6, WIN_SCORE=3, MAX_LEVEL=2):
- Start pulse: reset then start_btn -> SERVE_WAIT for 4 cycles, then game_on=1 and ball_reset=0.
- Scoring: in RALLY, p1_point -> p1_score=1, POINT_PAUSE for 4 cycles, back to RALLY. Simultaneous p1/p2 pulses -> scores unchanged, POINT_PAUSE.
- Level win: three p2_point pulses -> winner=10, WIN_HOLD for 6 cycles, then lvl_up high exactly 1 cycle, level=2, scores=0, SERVE_WAIT.
- Final level: repeat the win at level 2 -> GAME_OVER, no lvl_up, level stays 2, winner held. start_btn -> level=1, scores 0.
- Pause mid-serve: pause_btn 2 cycles into SERVE_WAIT -> PAUSED, game_on=0; p1_point while paused ignored. pause_btn -> remaining 2 cycles of SERVE_WAIT, then RALLY.
- Async reset during WIN_HOLD: assert reset -> immediate IDLE, outputs at reset values, no lvl_up pulse after release.
